// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between writeback (port 0) and debug (port 1) round-robin, plus a zero-fill sweep.
// Latency: grant to rf_we is 1 cycle; ready is combinational, and both readies drop for the whole sweep.
module rf_write_arbiter #(
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int ZERO_X0 = 1,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            v0,
    input  logic [AW-1:0]   a0,
    input  logic [DW-1:0]   d0,
    output logic            r0,
    input  logic            v1,
    input  logic [AW-1:0]   a1,
    input  logic [DW-1:0]   d1,
    output logic            r1,
    input  logic            clr_start,
    output logic            busy,
    output logic            clr_done,
    output logic            rf_we,
    output logic [AW-1:0]   rf_wa,
    output logic [DW-1:0]   rf_wd,
    output logic [CNTW-1:0] stall_cnt
);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t        state;
    logic          last;
    logic [AW-1:0] clr_addr;
    logic          stall;

    // last==1 means port 1 was served most recently, so port 0 wins a tie
    always_comb begin
        r0    = (state == ARB) && v0 && (!v1 || last);
        r1    = (state == ARB) && v1 && (!v0 || !last);
        stall = (v0 && !r0) || (v1 && !r1);
    end

    assign busy = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB;
            last      <= 1'b1;
            clr_addr  <= '0;
            rf_we     <= 1'b0;
            rf_wa     <= '0;
            rf_wd     <= '0;
            clr_done  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            clr_done <= 1'b0;
            if (stall && (stall_cnt != {CNTW{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;

            case (state)
                ARB: begin
                    rf_we <= 1'b0;
                    if (r0) begin
                        last  <= 1'b0;
                        rf_wa <= a0;
                        rf_wd <= d0;
                        rf_we <= !((ZERO_X0 != 0) && (a0 == '0));
                    end else if (r1) begin
                        last  <= 1'b1;
                        rf_wa <= a1;
                        rf_wd <= d1;
                        rf_we <= !((ZERO_X0 != 0) && (a1 == '0));
                    end
                    if (clr_start) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end
                end
                CLEAR: begin
                    // the sweep writes address 0 too, regardless of the x0 filter
                    rf_we    <= 1'b1;
                    rf_wa    <= clr_addr;
                    rf_wd    <= '0;
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == {AW{1'b1}}) begin
                        state    <= ARB;
                        clr_done <= 1'b1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench: a vector table for arbitration and the x0 filter, plus hand sequences for the clear sweep and reset abort.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, clr_start;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;

    logic        r0, r1, busy, clr_done, rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [15:0] stall_cnt;

    logic        n_r0, n_r1, n_busy, n_clr_done, n_rf_we;
    logic [4:0]  n_rf_wa;
    logic [31:0] n_rf_wd;
    logic [3:0]  n_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.AW(5), .DW(32), .ZERO_X0(1), .CNTW(16)) dut (
        .clk(clk), .rst(rst),
        .v0(v0), .a0(a0), .d0(d0), .r0(r0),
        .v1(v1), .a1(a1), .d1(d1), .r1(r1),
        .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .stall_cnt(stall_cnt)
    );

    // Second instance: x0 passed through and a narrow counter to reach saturation quickly
    rf_write_arbiter #(.AW(5), .DW(32), .ZERO_X0(0), .CNTW(4)) dut_nz (
        .clk(clk), .rst(rst),
        .v0(v0), .a0(a0), .d0(d0), .r0(n_r0),
        .v1(v1), .a1(a1), .d1(d1), .r1(n_r1),
        .clr_start(clr_start), .busy(n_busy), .clr_done(n_clr_done),
        .rf_we(n_rf_we), .rf_wa(n_rf_wa), .rf_wd(n_rf_wd), .stall_cnt(n_stall_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive point: 1 time unit after the rising edge; samples taken 2 units later
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        we;
        logic        we_nz;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [15:0] stall;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // registered expectations are the outputs visible during that row's cycle
        vecs[0] = '{0, 0, 0,            0, 0, 0,  0, 0, 0, 0, 0, 0,            0};
        vecs[1] = '{1, 5, 32'hDEADBEEF, 0, 0, 0,  1, 0, 0, 0, 0, 0,            0};
        vecs[2] = '{0, 0, 0,            0, 0, 0,  0, 0, 1, 1, 5, 32'hDEADBEEF, 0};
        vecs[3] = '{0, 0, 0,            1, 0, 7,  0, 1, 0, 0, 5, 32'hDEADBEEF, 0};
        vecs[4] = '{1, 1, 32'h11,       1, 2, 32'h22, 1, 0, 0, 1, 0, 7,        0};
        vecs[5] = '{1, 1, 32'h11,       1, 2, 32'h22, 0, 1, 1, 1, 1, 32'h11,   1};
        vecs[6] = '{1, 1, 32'h11,       1, 2, 32'h22, 1, 0, 1, 1, 2, 32'h22,   2};
        vecs[7] = '{1, 1, 32'h11,       1, 2, 32'h22, 0, 1, 1, 1, 1, 32'h11,   3};
        vecs[8] = '{0, 0, 0,            0, 0, 0,  0, 0, 1, 1, 2, 32'h22,       4};
        vecs[9] = '{0, 0, 0,            0, 0, 0,  0, 0, 0, 0, 2, 32'h22,       4};

        rst = 1'b1; v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0; clr_start = 0;

        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #2;
            chk("rst_r0", r0, 0);
            chk("rst_r1", r1, 0);
            chk("rst_we", rf_we, 0);
            chk("rst_busy", busy, 0);
            chk("rst_stall", stall_cnt, 0);
        end
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            next_cycle();
            v0 = vecs[i].v0; a0 = vecs[i].a0; d0 = vecs[i].d0;
            v1 = vecs[i].v1; a1 = vecs[i].a1; d1 = vecs[i].d1;
            #2;
            chk($sformatf("vec%0d_r0", i), r0, vecs[i].r0);
            chk($sformatf("vec%0d_r1", i), r1, vecs[i].r1);
            chk($sformatf("vec%0d_we", i), rf_we, vecs[i].we);
            chk($sformatf("vec%0d_wa", i), rf_wa, vecs[i].wa);
            chk($sformatf("vec%0d_wd", i), rf_wd, vecs[i].wd);
            chk($sformatf("vec%0d_stall", i), stall_cnt, vecs[i].stall);
            chk($sformatf("vec%0d_nz_we", i), n_rf_we, vecs[i].we_nz);
            chk($sformatf("vec%0d_nz_wa", i), n_rf_wa, vecs[i].wa);
            chk($sformatf("vec%0d_nz_wd", i), n_rf_wd, vecs[i].wd);
            chk($sformatf("vec%0d_nz_stall", i), n_stall_cnt, vecs[i].stall[3:0]);
        end

        // Clear sweep with port 0 held off, and a redundant clr_start mid-sweep
        next_cycle();
        clr_start = 1'b1;
        #2;
        chk("clr_c0_busy", busy, 0);
        for (int k = 1; k <= 32; k++) begin
            next_cycle();
            clr_start = (k == 5);
            v0 = 1'b1; a0 = 9; d0 = 32'h99;
            #2;
            chk($sformatf("clr_c%0d_busy", k), busy, 1);
            chk($sformatf("clr_c%0d_r0", k), r0, 0);
            chk($sformatf("clr_c%0d_done", k), clr_done, 0);
            if (k == 1) begin
                chk("clr_c1_we", rf_we, 0);
            end else begin
                chk($sformatf("clr_c%0d_we", k), rf_we, 1);
                chk($sformatf("clr_c%0d_wa", k), rf_wa, k - 2);
                chk($sformatf("clr_c%0d_wd", k), rf_wd, 0);
            end
        end
        next_cycle();
        clr_start = 1'b0;
        #2;
        chk("clr_end_busy", busy, 0);
        chk("clr_end_done", clr_done, 1);
        chk("clr_end_r0", r0, 1);
        chk("clr_end_we", rf_we, 1);
        chk("clr_end_wa", rf_wa, 31);
        chk("clr_end_wd", rf_wd, 0);
        chk("clr_end_stall", stall_cnt, 36);
        chk("clr_end_nz_stall_sat", n_stall_cnt, 15);
        chk("clr_end_nz_done", n_clr_done, 1);
        next_cycle();
        v0 = 1'b0;
        #2;
        chk("post_clr_done", clr_done, 0);
        chk("post_clr_we", rf_we, 1);
        chk("post_clr_wa", rf_wa, 9);
        chk("post_clr_wd", rf_wd, 32'h99);
        chk("post_clr_nz_stall_hold", n_stall_cnt, 15);

        // Reset while the sweep is issuing address 10
        next_cycle();
        clr_start = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            next_cycle();
            clr_start = 1'b0;
        end
        #2;
        chk("abort_pre_busy", busy, 1);
        chk("abort_pre_wa", rf_wa, 9);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #2;
        chk("abort_we", rf_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_stall", stall_cnt, 0);
        begin
            int dones = 0;
            for (int k = 0; k < 40; k++) begin
                next_cycle();
                #2;
                if (clr_done) dones++;
            end
            chk("abort_no_done", dones, 0);
        end

        // Restart after abort begins again at address 0
        next_cycle();
        clr_start = 1'b1;
        next_cycle();
        clr_start = 1'b0;
        next_cycle();
        #2;
        chk("restart_we", rf_we, 1);
        chk("restart_wa0", rf_wa, 0);
        next_cycle();
        #2;
        chk("restart_wa1", rf_wa, 1);
        begin
            int waited = 0;
            while (!clr_done && waited < 50) begin
                next_cycle();
                #2;
                waited++;
            end
            chk("restart_done_seen", clr_done, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
